// File: rtl/ifu_pc_if.sv
// ifu_pc_if -- fetch-unit bus between the PC unit and the rest of the core.
//
// Carried signals:
//   en        advance enable (0 = stall)
//   npc_op    next-PC select (000 PC4, 001 BEQ, 010 BNE, 011 J/JAL, 100 JR)
//   imm16     signed branch offset in words
//   imm26     jump index field
//   rs_data   register operand rs (branch compare, JR target)
//   rt_data   register operand rt (branch compare)
//   pc        current fetch address
//   pc_plus8  pc + 8, JAL link value
//   npc       combinational next-PC candidate
//   taken     selected op redirects flow
//   fault     sticky flag: an illegal next-PC was rejected
//   halted    unit is in HALT
//   fetch_cnt count of accepted PC advances
//
// Modports: master drives the control/operand side, slave is the PC unit.
interface ifu_pc_if;
  logic        en;
  logic [2:0]  npc_op;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] pc;
  logic [31:0] pc_plus8;
  logic [31:0] npc;
  logic        taken;
  logic        fault;
  logic        halted;
  logic [31:0] fetch_cnt;

  modport master (
    output en, npc_op, imm16, imm26, rs_data, rt_data,
    input  pc, pc_plus8, npc, taken, fault, halted, fetch_cnt
  );

  modport slave (
    input  en, npc_op, imm16, imm26, rs_data, rt_data,
    output pc, pc_plus8, npc, taken, fault, halted, fetch_cnt
  );
endinterface

// File: rtl/ifu_pc.sv
// ifu_pc -- program counter and next-PC selection for the instruction fetch unit.
//
// Computes the next fetch address from the current PC and the decoded control
// (sequential, conditional branch, jump, jump-register). It accepts the
// candidate only when it is word aligned and inside [PC_INIT, PC_MAX].
// An out-of-range or misaligned candidate freezes the unit in HALT with a
// sticky fault until reset.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    ifu_pc_if.slave (see interface header for signal list)
//
// Parameters:
//   PC_INIT  reset PC and lowest legal fetch address
//   PC_MAX   highest legal fetch address
module ifu_pc #(
  parameter logic [31:0] PC_INIT = 32'h0000_3000,
  parameter logic [31:0] PC_MAX  = 32'h0000_6FFC
) (
  input logic       clk,
  input logic       reset,
  ifu_pc_if.slave   bus
);

  localparam logic [2:0] OP_PC4 = 3'b000;
  localparam logic [2:0] OP_BEQ = 3'b001;
  localparam logic [2:0] OP_BNE = 3'b010;
  localparam logic [2:0] OP_J   = 3'b011;
  localparam logic [2:0] OP_JR  = 3'b100;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] fetch_cnt_reg;
  logic        fault_reg;
  logic        halted_reg;

  logic [31:0] pc_plus4;
  logic [31:0] branch_off;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic        operands_equal;
  logic [31:0] npc_next;
  logic        taken_next;
  logic        npc_legal;

  // ---------------------------------------------------------------------------
  // Next-PC candidate: purely a function of the current pc and the inputs,
  // so the decode stage can see the redirect in the same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_plus4       = pc_reg + 32'd4;
    // Word offset -> byte offset: sign-extend then shift left by two.
    branch_off     = {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
    branch_target  = pc_plus4 + branch_off;
    // Jumps stay within the current 256 MB region.
    jump_target    = {pc_reg[31:28], bus.imm26, 2'b00};
    operands_equal = (bus.rs_data == bus.rt_data);

    npc_next   = pc_plus4;
    taken_next = 1'b0;
    case (bus.npc_op)
      OP_BEQ: begin
        if (operands_equal) begin
          npc_next   = branch_target;
          taken_next = 1'b1;
        end
      end
      OP_BNE: begin
        if (!operands_equal) begin
          npc_next   = branch_target;
          taken_next = 1'b1;
        end
      end
      OP_J: begin
        npc_next   = jump_target;
        taken_next = 1'b1;
      end
      OP_JR: begin
        npc_next   = bus.rs_data;
        taken_next = 1'b1;
      end
      default: begin
        // OP_PC4 and the unused encodings fall through sequentially.
        npc_next   = pc_plus4;
        taken_next = 1'b0;
      end
    endcase

    // Unsigned window check; alignment is checked on the raw candidate so a
    // misaligned JR target is rejected rather than silently truncated.
    npc_legal = (npc_next[1:0] == 2'b00) &&
                (npc_next >= PC_INIT) &&
                (npc_next <= PC_MAX);
  end

  // ---------------------------------------------------------------------------
  // RUN/HALT control with registered status outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_RUN;
      pc_reg        <= PC_INIT;
      fetch_cnt_reg <= 32'd0;
      fault_reg     <= 1'b0;
      halted_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (bus.en) begin
            if (npc_legal) begin
              pc_reg        <= npc_next;
              // Wraps naturally at 2^32.
              fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
            end else begin
              // Keep the last good pc so the faulting fetch can be inspected.
              fault_reg  <= 1'b1;
              halted_reg <= 1'b1;
              state_reg  <= ST_HALT;
            end
          end
        end
        ST_HALT: begin
          // Terminal: only reset leaves this state.
          halted_reg <= 1'b1;
        end
        default: begin
          state_reg  <= ST_HALT;
          fault_reg  <= 1'b1;
          halted_reg <= 1'b1;
        end
      endcase
    end
  end

  assign bus.pc        = pc_reg;
  assign bus.pc_plus8  = pc_reg + 32'd8;
  assign bus.npc       = npc_next;
  assign bus.taken     = taken_next;
  assign bus.fault     = fault_reg;
  assign bus.halted    = halted_reg;
  assign bus.fetch_cnt = fetch_cnt_reg;

endmodule

// File: tb/tb_ifu_pc.sv
// tb_ifu_pc -- directed scoreboard bench for ifu_pc.
module tb_ifu_pc;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  ifu_pc_if bus ();

  ifu_pc #(
    .PC_INIT(32'h0000_3000),
    .PC_MAX (32'h0000_6FFC)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] cnt;
    logic        fault;
    logic        halted;
  } exp_t;

  exp_t sb_q[$];

  int vectors     = 0;
  int miscompares = 0;

  // Reference state of the unit.
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic        m_fault;
  logic        m_halted;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic is_legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= 32'h0000_3000) && (a <= 32'h0000_6FFC);
  endfunction

  task automatic model_reset();
    m_pc     = 32'h0000_3000;
    m_cnt    = 32'd0;
    m_fault  = 1'b0;
    m_halted = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check32({tag, ".pc"},     bus.pc,                m_pc);
    check32({tag, ".cnt"},    bus.fetch_cnt,         m_cnt);
    check32({tag, ".fault"},  {31'd0, bus.fault},    {31'd0, m_fault});
    check32({tag, ".halted"}, {31'd0, bus.halted},   {31'd0, m_halted});
  endtask

  // One directed step: drive, check combinational outputs, push the
  // expected post-edge state, clock, then pop and compare.
  task automatic step(input string tag, input logic en, input logic [2:0] op,
                      input logic [15:0] i16, input logic [25:0] i26,
                      input logic [31:0] rs, input logic [31:0] rt,
                      input logic [31:0] exp_pc);
    logic [31:0] t;
    logic        tk;
    logic [31:0] seq;
    exp_t        e;
    exp_t        got;
    bus.en      = en;
    bus.npc_op  = op;
    bus.imm16   = i16;
    bus.imm26   = i26;
    bus.rs_data = rs;
    bus.rt_data = rt;
    #1;
    seq = m_pc + 32'd4;
    t   = seq;
    tk  = 1'b0;
    if (op == 3'b001 && rs == rt) begin
      t  = seq + {{14{i16[15]}}, i16, 2'b00};
      tk = 1'b1;
    end else if (op == 3'b010 && rs != rt) begin
      t  = seq + {{14{i16[15]}}, i16, 2'b00};
      tk = 1'b1;
    end else if (op == 3'b011) begin
      t  = {m_pc[31:28], i26, 2'b00};
      tk = 1'b1;
    end else if (op == 3'b100) begin
      t  = rs;
      tk = 1'b1;
    end
    check32({tag, ".npc"},   bus.npc,             t);
    check32({tag, ".taken"}, {31'd0, bus.taken},  {31'd0, tk});

    if (!m_halted && en) begin
      if (is_legal(t)) begin
        m_cnt = m_cnt + 32'd1;
      end else begin
        m_fault  = 1'b1;
        m_halted = 1'b1;
      end
    end
    m_pc     = exp_pc;
    e.pc     = exp_pc;
    e.cnt    = m_cnt;
    e.fault  = m_fault;
    e.halted = m_halted;
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check32({tag, ".pc"},       bus.pc,              got.pc);
    check32({tag, ".pc_plus8"}, bus.pc_plus8,        got.pc + 32'd8);
    check32({tag, ".cnt"},      bus.fetch_cnt,       got.cnt);
    check32({tag, ".fault"},    {31'd0, bus.fault},  {31'd0, got.fault});
    check32({tag, ".halted"},   {31'd0, bus.halted}, {31'd0, got.halted});
    $display("step %-10s en=%0b op=%0d pc=%h cnt=%0d fault=%0b halted=%0b",
             tag, en, op, bus.pc, bus.fetch_cnt, bus.fault, bus.halted);
  endtask

  // Raise reset between edges and check it acts before the next edge.
  task automatic async_reset(input string tag);
    #2;
    bus.en = 1'b0;
    reset  = 1'b1;
    #1;
    model_reset();
    check_state(tag);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_state({tag, ".post"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    bus.en      = 1'b1;
    bus.npc_op  = 3'b000;
    bus.imm16   = 16'h0000;
    bus.imm26   = 26'h0;
    bus.rs_data = 32'h0;
    bus.rt_data = 32'h0;
    model_reset();
    #2;
    check_state("reset");
    // Edges while reset is held (with en=1) must be ignored.
    @(posedge clk);
    @(posedge clk);
    #1;
    check_state("reset_hold");
    reset = 1'b0;

    step("pc4_a", 1'b1, 3'b000, 16'h0, 26'h0, 32'h0, 32'h0, 32'h3004);
    step("pc4_b", 1'b1, 3'b000, 16'h0, 26'h0, 32'h0, 32'h0, 32'h3008);
    step("pc4_c", 1'b1, 3'b000, 16'h0, 26'h0, 32'h0, 32'h0, 32'h300C);
    check32("seq.cnt3",  bus.fetch_cnt, 32'd3);
    check32("seq.plus8", bus.pc_plus8,  32'h3014);
    step("pc4_d", 1'b1, 3'b000, 16'h0, 26'h0, 32'h0, 32'h0, 32'h3010);

    step("beq_tk",  1'b1, 3'b001, 16'hFFFC, 26'h0, 32'd5, 32'd5, 32'h3004);
    step("pc4_e",   1'b1, 3'b000, 16'h0, 26'h0, 32'h0, 32'h0, 32'h3008);
    step("pc4_f",   1'b1, 3'b000, 16'h0, 26'h0, 32'h0, 32'h0, 32'h300C);
    step("pc4_g",   1'b1, 3'b000, 16'h0, 26'h0, 32'h0, 32'h0, 32'h3010);
    step("beq_nt",  1'b1, 3'b001, 16'hFFFC, 26'h0, 32'd5, 32'd6, 32'h3014);
    step("bne_tk",  1'b1, 3'b010, 16'h0002, 26'h0, 32'd5, 32'd6, 32'h3020);
    step("bne_nt",  1'b1, 3'b010, 16'h0002, 26'h0, 32'd7, 32'd7, 32'h3024);

    step("jr_3000", 1'b1, 3'b100, 16'h0, 26'h0, 32'h3000, 32'h0, 32'h3000);
    step("j_3040",  1'b1, 3'b011, 16'h0, 26'h0000C10, 32'h0, 32'h0, 32'h3040);
    step("jr_4000", 1'b1, 3'b100, 16'h0, 26'h0, 32'h4000, 32'h0, 32'h4000);

    for (int i = 0; i < 4; i++)
      step("stall", 1'b0, 3'b011, 16'h0, 26'h0000C40, 32'h0, 32'h0, 32'h4000);
    step("j_3100",  1'b1, 3'b011, 16'h0, 26'h0000C40, 32'h0, 32'h0, 32'h3100);
    step("op101",   1'b1, 3'b101, 16'h0, 26'h0, 32'h0, 32'h0, 32'h3104);
    step("op111",   1'b1, 3'b111, 16'h0, 26'h0, 32'h0, 32'h0, 32'h3108);

    // Large negative offset wraps below zero -> illegal.
    step("beq_wrap", 1'b1, 3'b001, 16'h8000, 26'h0, 32'd1, 32'd1, 32'h3108);
    step("halt_jr",  1'b1, 3'b100, 16'h0, 26'h0, 32'h4000, 32'h0, 32'h3108);
    async_reset("rst_a");
    step("resume_a", 1'b1, 3'b000, 16'h0, 26'h0, 32'h0, 32'h0, 32'h3004);

    step("jr_top",   1'b1, 3'b100, 16'h0, 26'h0, 32'h6FFC, 32'h0, 32'h6FFC);
    step("pc4_7000", 1'b1, 3'b000, 16'h0, 26'h0, 32'h0, 32'h0, 32'h6FFC);
    step("halt_j",   1'b1, 3'b011, 16'h0, 26'h0000C10, 32'h0, 32'h0, 32'h6FFC);
    step("halt_pc4", 1'b1, 3'b000, 16'h0, 26'h0, 32'h0, 32'h0, 32'h6FFC);
    async_reset("rst_b");
    step("resume_b", 1'b1, 3'b000, 16'h0, 26'h0, 32'h0, 32'h0, 32'h3004);

    step("jr_mis",   1'b1, 3'b100, 16'h0, 26'h0, 32'h4002, 32'h0, 32'h3004);
    async_reset("rst_c");
    step("jr_low",   1'b1, 3'b100, 16'h0, 26'h0, 32'h2FFC, 32'h0, 32'h3000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ifu_pc.md
IFU_PC -- requirements
Module: ifu_pc

Interface
REQ-001 Parameter PC_INIT, default 32'h0000_3000, is the PC value loaded by reset and the lowest legal fetch address.
REQ-002 Parameter PC_MAX, default 32'h0000_6FFC, is the highest legal fetch address (4096-word instruction store).
REQ-003 clk  input  1  Single clock; all state updates on its rising edge.
REQ-004 reset  input  1  Asynchronous, active-high reset.
REQ-005 en  input  1  Advance enable; 0 = stall, PC holds.
REQ-006 npc_op  input  3  Next-PC select: 000 PC4, 001 BEQ, 010 BNE, 011 J/JAL, 100 JR; 101-111 treated as PC4.
REQ-007 imm16  input  16  Branch offset in words, signed.
REQ-008 imm26  input  26  Jump index field.
REQ-009 rs_data  input  32  Register operand rs; compared for branches; JR target.
REQ-010 rt_data  input  32  Register operand rt; compared for branches.
REQ-011 pc  output  32  Current fetch address, driven directly to the instruction store.
REQ-012 pc_plus8  output  32  pc + 8, the link value for JAL.
REQ-013 npc  output  32  Combinational next-PC candidate.
REQ-014 taken  output  1  Combinational: selected op redirects flow (taken branch, J/JAL, JR).
REQ-015 fault  output  1  Registered sticky flag: an illegal next-PC was rejected.
REQ-016 halted  output  1  Registered: unit is in HALT state.
REQ-017 fetch_cnt  output  32  Registered count of accepted PC advances.

Function
REQ-018 Sequential target = pc + 4; all adds are 32-bit modulo 2^32.
REQ-019 Branch target = pc + 4 + (sign-extended imm16 << 2).
REQ-020 BEQ is taken iff rs_data == rt_data; BNE is taken iff rs_data != rt_data; an untaken branch selects pc + 4.
REQ-021 J/JAL target = {pc[31:28], imm26, 2'b00}.
REQ-022 JR target = rs_data, unmodified.
REQ-023 npc and taken are purely combinational functions of the current pc and inputs, independent of en and state.
REQ-024 npc is legal iff npc[1:0] == 0 and PC_INIT <= npc <= PC_MAX (unsigned comparison).
REQ-025 The state machine has two states. RUN is the reset state. HALT is terminal.
REQ-026 In RUN, when en=1 and npc is legal, the next edge loads pc <= npc and increments fetch_cnt by 1; fetch_cnt wraps from FFFF_FFFF to 0.
REQ-027 In RUN, when en=1 and npc is illegal, the next edge holds pc, holds fetch_cnt, sets fault=1, and enters HALT.
REQ-028 In RUN with en=0, pc, fetch_cnt, fault and state all hold, whatever npc_op is.
REQ-029 In HALT, pc, fetch_cnt and fault hold, and halted=1; only reset leaves HALT.
REQ-030 halted = 1 exactly when state is HALT; fault is 1 from the HALT-entry edge until reset.
REQ-031 Latency: a redirect presented in the cycle where pc = A is visible on pc one edge later; there are no delay slots and no bubbles.
REQ-032 pc_plus8 always reflects the current registered pc, including while stalled or halted.

Reset
REQ-033 Asserting reset at any time, including mid-stall or in HALT, immediately sets pc=PC_INIT, fetch_cnt=0, fault=0, halted=0 and state=RUN, without waiting for a clock edge.
REQ-034 While reset is high, all clock edges are ignored.
REQ-035 After reset deasserts, the first edge with en=1 performs a normal advance from PC_INIT.

Verification
REQ-036 Reset, then 3 edges with en=1 and npc_op=000 -> pc sequence 3000, 3004, 3008, 300C; fetch_cnt = 3; pc_plus8 = 3014.
REQ-037 At pc=3010, BEQ with imm16=FFFC and rs=rt=5 -> taken=1, npc=3004, next pc=3004. Repeat with rs=5, rt=6 -> taken=0, next pc=3014.
REQ-038 At pc=3000, J with imm26=0000C10 -> next pc=3040. JR with rs_data=4000 -> next pc=4000. JR with rs_data=4002 -> pc holds, fault=1, halted=1.
REQ-039 At pc=6FFC, PC4 -> npc=7000 (illegal) -> pc stays 6FFC and HALT is entered. Later edges with legal ops leave pc, fault and fetch_cnt unchanged.
REQ-040 en=0 for 4 edges with npc_op=011 -> pc and fetch_cnt unchanged. Then en=1 -> jump taken on the next edge.
REQ-041 Reset is asserted asynchronously between edges while in HALT at pc=6FFC -> pc=3000, fault=0 and halted=0 before the next edge; normal advance resumes after deassertion.
